// File: rtl/microsequencer.sv
// Microprogram sequencer: microstate register, next-state select, one-level
// call/return, stall-until-condition hold and a memory-wait watchdog.
module microsequencer #(
  parameter int unsigned          STATE_W     = 7,
  parameter logic [STATE_W-1:0]   RESET_STATE = 7'd0,
  parameter logic [STATE_W-1:0]   FETCH_STATE = 7'd1,
  parameter logic [STATE_W-1:0]   FAULT_STATE = 7'd127,
  parameter logic [7:0]           MAX_WAIT    = 8'd16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt,
  input  logic [2:0]         ns_sel,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [STATE_W-1:0] enc_addr,
  input  logic [1:0]         cond_sel,
  input  logic               inv,
  input  logic               moc,
  input  logic               cc_true,
  input  logic               ir_bit,
  output logic [STATE_W-1:0] state,
  output logic               stall,
  output logic               fault
);

  typedef enum logic [2:0] {
    NS_DISPATCH = 3'd0,
    NS_FETCH    = 3'd1,
    NS_JUMP     = 3'd2,
    NS_BRANCH   = 3'd3,
    NS_INCR     = 3'd4,
    NS_CALL     = 3'd5,
    NS_RETURN   = 3'd6,
    NS_HOLD     = 3'd7
  } ns_e;

  localparam logic [STATE_W-1:0] ONE        = STATE_W'(1);
  localparam logic [7:0]         WAIT_LIMIT = MAX_WAIT - 8'd1;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] r_ret_addr;
  logic [7:0]         r_wait_cnt;
  logic               r_fault;

  ns_e                w_ns;
  logic [3:0]         w_src;
  logic               w_cond;
  logic [STATE_W-1:0] w_inc;
  logic               w_hold_wait;
  logic               w_trip;
  logic [STATE_W-1:0] w_next;

  assign w_ns        = ns_e'(ns_sel);
  assign w_src       = {1'b1, ir_bit, cc_true, moc};
  assign w_cond      = w_src[cond_sel] ^ inv;
  assign w_inc       = r_state + ONE;
  assign w_hold_wait = (w_ns == NS_HOLD) && !w_cond;
  assign w_trip      = (MAX_WAIT != 8'd0) && (r_wait_cnt == WAIT_LIMIT) && w_hold_wait;

  always_comb begin
    w_next = w_inc;
    case (w_ns)
      NS_DISPATCH: w_next = enc_addr;
      NS_FETCH:    w_next = FETCH_STATE;
      NS_JUMP:     w_next = cr_addr;
      NS_BRANCH:   w_next = w_cond ? cr_addr : w_inc;
      NS_INCR:     w_next = w_inc;
      NS_CALL:     w_next = cr_addr;
      NS_RETURN:   w_next = r_ret_addr;
      NS_HOLD:     w_next = w_cond ? w_inc : r_state;
      default:     w_next = w_inc;
    endcase
  end

  // Halt freezes every register; a watchdog trip overrides the ROM decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RESET_STATE;
      r_ret_addr <= '0;
      r_wait_cnt <= 8'd0;
      r_fault    <= 1'b0;
    end else if (!halt) begin
      if (w_trip) begin
        r_state    <= FAULT_STATE;
        r_fault    <= 1'b1;
        r_wait_cnt <= 8'd0;
      end else begin
        r_state    <= w_next;
        r_wait_cnt <= w_hold_wait ? r_wait_cnt + 8'd1 : 8'd0;
        if (w_ns == NS_CALL) begin
          r_ret_addr <= w_inc;
        end
      end
    end
  end

  assign state = r_state;
  assign fault = r_fault;
  assign stall = rst_n & ~halt & w_hold_wait;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: directed per-cycle vectors push the
// expected mid-cycle outputs; a monitor pops and compares on each falling edge.
module tb_microsequencer;

  logic       clk;
  logic       rst_n;
  logic       halt;
  logic [2:0] ns_sel;
  logic [6:0] cr_addr;
  logic [6:0] enc_addr;
  logic [1:0] cond_sel;
  logic       inv;
  logic       moc;
  logic       cc_true;
  logic       ir_bit;
  logic [6:0] state;
  logic       stall;
  logic       fault;

  typedef struct {
    logic [6:0] st;
    logic       sl;
    logic       fl;
    string      nm;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  microsequencer #(
    .STATE_W    (7),
    .RESET_STATE(7'd0),
    .FETCH_STATE(7'd1),
    .FAULT_STATE(7'd127),
    .MAX_WAIT   (8'd4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .halt    (halt),
    .ns_sel  (ns_sel),
    .cr_addr (cr_addr),
    .enc_addr(enc_addr),
    .cond_sel(cond_sel),
    .inv     (inv),
    .moc     (moc),
    .cc_true (cc_true),
    .ir_bit  (ir_bit),
    .state   (state),
    .stall   (stall),
    .fault   (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string nm, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", nm, what, act, exp);
    end
  endtask

  // Expected values describe the cycle the vector is applied in: state is
  // the result of the previous edge, stall reflects the inputs just driven.
  task automatic applyStimulus(input logic r, input logic h, input logic [2:0] ns,
                               input logic [1:0] cs, input logic iv, input logic m,
                               input logic cc, input logic ir, input logic [6:0] cr,
                               input logic [6:0] enc, input logic [6:0] est,
                               input logic es, input logic ef, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = r;
    halt     = h;
    ns_sel   = ns;
    cond_sel = cs;
    inv      = iv;
    moc      = m;
    cc_true  = cc;
    ir_bit   = ir;
    cr_addr  = cr;
    enc_addr = enc;
    e.st = est;
    e.sl = es;
    e.fl = ef;
    e.nm = nm;
    expQ.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.nm, "state", int'(state), int'(e.st));
        checkOutput(e.nm, "stall", int'(stall), int'(e.sl));
        checkOutput(e.nm, "fault", int'(fault), int'(e.fl));
      end
    end
  end

  initial begin
    rst_n = 1'b0; halt = 1'b0; ns_sel = 3'd7; cond_sel = 2'd0; inv = 1'b0;
    moc = 1'b0; cc_true = 1'b1; ir_bit = 1'b1; cr_addr = 7'd99; enc_addr = 7'd77;

    // reset held with inputs that would otherwise stall/advance
    applyStimulus(0,0,3'd7,2'd0,0,0,1,1,7'd99,7'd77, 7'd0,0,0,"rst_hold0");
    applyStimulus(0,0,3'd2,2'd1,1,1,0,0,7'd55,7'd12, 7'd0,0,0,"rst_hold1");
    applyStimulus(1,0,3'd4,2'd0,0,0,0,0,7'd0,7'd0,   7'd0,0,0,"rel_0");
    applyStimulus(1,0,3'd4,2'd0,0,0,0,0,7'd0,7'd0,   7'd1,0,0,"rel_1");
    applyStimulus(1,0,3'd2,2'd0,0,0,0,0,7'd5,7'd0,   7'd2,0,0,"rel_2");

    // branch
    applyStimulus(1,0,3'd3,2'd1,0,0,1,0,7'd40,7'd0,  7'd5,0,0,"br_taken_at5");
    applyStimulus(1,0,3'd2,2'd0,0,0,0,0,7'd5,7'd0,   7'd40,0,0,"br_taken_40");
    applyStimulus(1,0,3'd3,2'd1,1,0,1,0,7'd40,7'd0,  7'd5,0,0,"br_inv_at5");
    applyStimulus(1,0,3'd3,2'd2,1,0,0,0,7'd70,7'd0,  7'd6,0,0,"br_inv_6");
    applyStimulus(1,0,3'd2,2'd0,0,0,0,0,7'd127,7'd0, 7'd70,0,0,"br_irbit_70");
    applyStimulus(1,0,3'd4,2'd0,0,0,0,0,7'd0,7'd0,   7'd127,0,0,"incr_at127");
    applyStimulus(1,0,3'd2,2'd0,0,0,0,0,7'd10,7'd0,  7'd0,0,0,"incr_wrap0");

    // memory wait: three false cycles, moc on the 4th (no trip at the boundary)
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,0,"mw_wait1");
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,0,"mw_wait2");
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,0,"mw_wait3");
    applyStimulus(1,0,3'd7,2'd0,0,1,0,0,7'd0,7'd0,   7'd10,0,0,"mw_moc");
    applyStimulus(1,0,3'd2,2'd0,0,0,0,0,7'd10,7'd0,  7'd11,0,0,"mw_adv11");

    // watchdog trip after four false cycles
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,0,"wd_1");
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,0,"wd_2");
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,0,"wd_3");
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,0,"wd_4");
    applyStimulus(1,0,3'd2,2'd0,0,0,0,0,7'd20,7'd0,  7'd127,0,1,"wd_trip");

    // subroutine, then nested call overwriting the return address
    applyStimulus(1,0,3'd5,2'd0,0,0,0,0,7'd60,7'd0,  7'd20,0,1,"sub_call");
    applyStimulus(1,0,3'd4,2'd0,0,0,0,0,7'd0,7'd0,   7'd60,0,1,"sub_60");
    applyStimulus(1,0,3'd6,2'd0,0,0,0,0,7'd0,7'd0,   7'd61,0,1,"sub_61");
    applyStimulus(1,0,3'd5,2'd0,0,0,0,0,7'd60,7'd0,  7'd21,0,1,"sub_ret21");
    applyStimulus(1,0,3'd4,2'd0,0,0,0,0,7'd0,7'd0,   7'd60,0,1,"nest_60");
    applyStimulus(1,0,3'd5,2'd0,0,0,0,0,7'd90,7'd0,  7'd61,0,1,"nest_call61");
    applyStimulus(1,0,3'd6,2'd0,0,0,0,0,7'd0,7'd0,   7'd90,0,1,"nest_90");
    applyStimulus(1,0,3'd6,2'd0,0,0,0,0,7'd0,7'd0,   7'd62,0,1,"nest_ret62");
    applyStimulus(1,0,3'd2,2'd0,0,0,0,0,7'd10,7'd0,  7'd62,0,1,"ret_keeps62");

    // halt during a hold with wait_cnt=2, then two more false cycles trip
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,1,"hlt_w1");
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,1,"hlt_w2");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1,1,3'd7,2'd0,0,0,0,0,7'd0,7'd0, 7'd10,0,1,"hlt_frozen");
    end
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,1,"hlt_w3");
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,1,"hlt_w4");
    applyStimulus(1,0,3'd0,2'd0,0,0,0,0,7'd0,7'd33,  7'd127,0,1,"hlt_trip");
    applyStimulus(1,0,3'd4,2'd0,0,0,0,0,7'd0,7'd0,   7'd33,0,1,"dispatch33");
    applyStimulus(1,0,3'd1,2'd0,0,0,0,0,7'd0,7'd0,   7'd34,0,1,"incr34");
    applyStimulus(1,0,3'd5,2'd0,0,0,0,0,7'd10,7'd0,  7'd1,0,1,"fetch1");

    // asynchronous reset mid-hold inside a subroutine drops the return address
    applyStimulus(1,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd10,1,1,"rst_midhold");
    applyStimulus(0,0,3'd7,2'd0,0,0,0,0,7'd0,7'd0,   7'd0,0,0,"rst_async");
    applyStimulus(1,0,3'd6,2'd0,0,0,0,0,7'd0,7'd0,   7'd0,0,0,"rst_rel");
    applyStimulus(1,0,3'd4,2'd0,0,0,0,0,7'd0,7'd0,   7'd0,0,0,"rst_retlost");
    applyStimulus(1,0,3'd4,2'd0,0,0,0,0,7'd0,7'd0,   7'd1,0,0,"rst_incr1");

    repeat (3) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
